fifo_playout_ctrl: RTL and testbench



---
 rtl/playout_pkg.sv | 19 +
 rtl/fifo_playout_ctrl_rate_timer.sv | 25 ++
 rtl/fifo_playout_ctrl.sv | 153 +++++++++++++++
 tb/tb_fifo_playout_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/playout_pkg.sv
// Shared types and constants for the FIFO-to-DAC playout sequencer.
package playout_pkg;

  localparam int DEFAULT_DW = 8;
  localparam int DEFAULT_CW = 8;

  // Shortest strobe-to-strobe spacing: one READ, one LOAD and one HOLD cycle.
  localparam int MIN_PERIOD = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_FULL,
    ST_READ,
    ST_LOAD,
    ST_HOLD,
    ST_DONE
  } playout_state_t;

endpackage

// File: rtl/fifo_playout_ctrl_rate_timer.sv
// Loadable saturating down-counter pacing the DAC strobes.
module rate_timer #(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [CW-1:0] load_value,
  output logic [CW-1:0] value,
  output logic          zero
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value <= '0;
    end else if (load) begin
      value <= load_value;
    end else if (value != '0) begin
      value <= value - CW'(1);
    end
  end

  assign zero = (value == '0);

endmodule

// File: rtl/fifo_playout_ctrl.sv
// Drains the sample FIFO into the DAC datapath, one strobe per rate period.
//   state     | meaning
//   IDLE      | waiting for start
//   WAIT_FULL | playout armed, FIFO not yet full
//   READ      | FIFO read strobe issued (or underrun detected)
//   LOAD      | FIFO data captured into dac_data
//   HOLD      | pacing until the rate timer expires
//   DONE      | one-cycle done pulse, then back to IDLE
module fifo_playout_ctrl
  import playout_pkg::*;
#(
  parameter int DW = DEFAULT_DW,
  parameter int CW = DEFAULT_CW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  input  logic [CW-1:0] rate_div,
  input  logic [CW-1:0] length,
  input  logic          fifo_full,
  input  logic          fifo_read_complete,
  input  logic [DW-1:0] fifo_data,
  output logic          fifo_rd_en,
  output logic [DW-1:0] dac_data,
  output logic          dac_valid,
  output logic          busy,
  output logic          done,
  output logic          underrun,
  output logic [CW-1:0] sample_cnt
);

  playout_state_t state, next_state;

  logic [CW-1:0] rate_q;
  logic [CW-1:0] len_q;

  logic          tmr_load;
  logic [CW-1:0] tmr_load_value;
  logic [CW-1:0] tmr_value;
  logic          tmr_zero;

  logic accept_start;
  logic take_sample;
  logic last_sample;
  logic set_underrun;

  // Between samples the READ and LOAD cycles are part of the period.
  function automatic logic [CW-1:0] period_load(input logic [CW-1:0] r);
    if (r >= CW'(MIN_PERIOD - 1)) return r - CW'(1);
    return '0;
  endfunction

  // After the last sample the full period is counted from the strobe.
  function automatic logic [CW-1:0] tail_load(input logic [CW-1:0] r);
    if (r >= CW'(MIN_PERIOD - 1)) return r;
    return '0;
  endfunction

  assign accept_start = (state == ST_IDLE) && start;
  assign take_sample  = (state == ST_LOAD) && !abort && (sample_cnt != len_q);
  assign last_sample  = (sample_cnt + CW'(1)) == len_q;
  // fifo_rd_en low in READ means the FIFO was already exhausted on entry.
  assign set_underrun = (state == ST_READ) && !fifo_rd_en && !abort;

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (length == '0)   next_state = ST_HOLD;
          else if (fifo_full) next_state = ST_READ;
          else                next_state = ST_WAIT_FULL;
        end
      end
      ST_WAIT_FULL: begin
        if (abort)          next_state = ST_DONE;
        else if (fifo_full) next_state = ST_READ;
      end
      ST_READ: begin
        if (abort || !fifo_rd_en) next_state = ST_DONE;
        else                      next_state = ST_LOAD;
      end
      ST_LOAD: begin
        if (abort) next_state = ST_DONE;
        else       next_state = ST_HOLD;
      end
      ST_HOLD: begin
        if (abort)                  next_state = ST_DONE;
        else if (tmr_zero)          next_state = (sample_cnt == len_q) ? ST_DONE : ST_READ;
      end
      ST_DONE: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    tmr_load       = 1'b0;
    tmr_load_value = '0;
    if (accept_start && (length == '0)) begin
      tmr_load = 1'b1;
    end else if (state == ST_READ) begin
      tmr_load       = 1'b1;
      tmr_load_value = period_load(rate_q);
    end else if (take_sample && last_sample) begin
      tmr_load       = 1'b1;
      tmr_load_value = tail_load(rate_q);
    end
  end

  rate_timer #(.CW(CW)) u_rate_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (tmr_load),
    .load_value (tmr_load_value),
    .value      (tmr_value),
    .zero       (tmr_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      rate_q     <= '0;
      len_q      <= '0;
      fifo_rd_en <= 1'b0;
      dac_data   <= '0;
      dac_valid  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      underrun   <= 1'b0;
      sample_cnt <= '0;
    end else begin
      state      <= next_state;
      fifo_rd_en <= (next_state == ST_READ) && !fifo_read_complete;
      dac_valid  <= take_sample;
      busy       <= (next_state != ST_IDLE);
      done       <= (next_state == ST_DONE);
      if (accept_start) begin
        rate_q     <= rate_div;
        len_q      <= length;
        sample_cnt <= '0;
        underrun   <= 1'b0;
      end else begin
        if (take_sample) begin
          dac_data   <= fifo_data;
          sample_cnt <= sample_cnt + CW'(1);
        end
        if (set_underrun) underrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_playout_ctrl.sv
// Directed bench for fifo_playout_ctrl with a behavioural FIFO model.
module tb_fifo_playout_ctrl;

  localparam int DW = 8;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [CW-1:0] rate_div = '0;
  logic [CW-1:0] length = '0;
  logic          fifo_full = 1'b0;
  logic          fifo_read_complete;
  logic [DW-1:0] fifo_data;
  logic          fifo_rd_en;
  logic [DW-1:0] dac_data;
  logic          dac_valid;
  logic          busy;
  logic          done;
  logic          underrun;
  logic [CW-1:0] sample_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  logic [DW-1:0] fifo_mem [0:7];
  int            fifo_cnt = 0;
  int            fifo_rp = 0;
  logic          fifo_clr = 1'b0;

  logic [63:0]   valid_mask, rd_mask, done_mask, busy_mask;
  logic [DW-1:0] vdat [0:7];
  int            vcnt;

  always #5 clk = ~clk;

  fifo_playout_ctrl #(.DW(DW), .CW(CW)) dut (
    .clk                (clk),
    .reset              (reset),
    .start              (start),
    .abort              (abort),
    .rate_div           (rate_div),
    .length             (length),
    .fifo_full          (fifo_full),
    .fifo_read_complete (fifo_read_complete),
    .fifo_data          (fifo_data),
    .fifo_rd_en         (fifo_rd_en),
    .dac_data           (dac_data),
    .dac_valid          (dac_valid),
    .busy               (busy),
    .done               (done),
    .underrun           (underrun),
    .sample_cnt         (sample_cnt)
  );

  // FIFO model: data_out valid the cycle after rd_en, read_complete after last entry.
  always @(posedge clk) begin
    if (fifo_clr) begin
      fifo_rp            <= 0;
      fifo_read_complete <= 1'b0;
      fifo_data          <= '0;
    end else if (fifo_rd_en) begin
      fifo_data <= fifo_mem[fifo_rp[2:0]];
      fifo_rp   <= fifo_rp + 1;
      if (fifo_rp + 1 >= fifo_cnt) fifo_read_complete <= 1'b1;
    end
  end

  function automatic logic [63:0] b(input int i);
    return 64'(1) << i;
  endfunction

  task automatic load_fifo(input int cnt, input logic [39:0] bytes);
    for (int i = 0; i < 5; i++) fifo_mem[i] = bytes[8*i +: 8];
    fifo_cnt = cnt;
    fifo_clr = 1'b1;
    @(posedge clk); #1;
    fifo_clr = 1'b0;
  endtask

  // Runs n cycles from posedge+1; cycle 0 is the first cycle of the run.
  task automatic run(input int n, input int start_at, input int start2_at,
                     input int abort_at, input int full_at);
    valid_mask = '0; rd_mask = '0; done_mask = '0; busy_mask = '0; vcnt = 0;
    for (int c = 0; c < n; c++) begin
      start     = (c == start_at) || (c == start2_at);
      abort     = (c == abort_at);
      fifo_full = (c >= full_at);
      @(negedge clk);
      if (dac_valid) begin
        valid_mask[c] = 1'b1;
        if (vcnt < 8) vdat[vcnt] = dac_data;
        vcnt++;
      end
      if (fifo_rd_en) rd_mask[c]   = 1'b1;
      if (done)       done_mask[c] = 1'b1;
      if (busy)       busy_mask[c] = 1'b1;
      @(posedge clk); #1;
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    fifo_clr = 1'b1;
    @(posedge clk); #1;
    fifo_clr = 1'b0;
    n_cmp++;
    if ({fifo_rd_en, dac_valid, busy, done, underrun, dac_data, sample_cnt} !== 21'd0) begin
      n_bad++;
      $display("FAIL reset_values: got %h want 0",
               {fifo_rd_en, dac_valid, busy, done, underrun, dac_data, sample_cnt});
    end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    load_fifo(3, 40'h00_00_03_02_01);
    length = 8'd3; rate_div = 8'd4;
    run(22, 0, -1, -1, 0);
    n_cmp++;
    if (valid_mask !== (b(3) | b(8) | b(13))) begin
      n_bad++; $display("FAIL basic_valid_cycles: got %h want %h", valid_mask, b(3) | b(8) | b(13));
    end
    n_cmp++;
    if ({vdat[0], vdat[1], vdat[2]} !== 24'h01_02_03) begin
      n_bad++; $display("FAIL basic_data: got %h want 010203", {vdat[0], vdat[1], vdat[2]});
    end
    n_cmp++;
    if (rd_mask !== (b(1) | b(6) | b(11))) begin
      n_bad++; $display("FAIL basic_rd_cycles: got %h want %h", rd_mask, b(1) | b(6) | b(11));
    end
    n_cmp++;
    if (done_mask !== b(18)) begin
      n_bad++; $display("FAIL basic_done_cycle: got %h want %h", done_mask, b(18));
    end
    n_cmp++;
    if (busy_mask !== (b(19) - b(1))) begin
      n_bad++; $display("FAIL basic_busy_span: got %h want %h", busy_mask, b(19) - b(1));
    end
    n_cmp++;
    if ({underrun, sample_cnt} !== {1'b0, 8'd3}) begin
      n_bad++; $display("FAIL basic_status: got underrun=%0b cnt=%0d want 0/3", underrun, sample_cnt);
    end
  endtask

  task automatic test_wait_full;
    load_fifo(1, 40'h00_00_00_00_0a);
    length = 8'd1; rate_div = 8'd2;
    run(20, 0, -1, -1, 10);
    n_cmp++;
    if (rd_mask !== b(11)) begin
      n_bad++; $display("FAIL wait_full_rd: got %h want %h", rd_mask, b(11));
    end
    n_cmp++;
    if (valid_mask !== b(13) || vdat[0] !== 8'h0a) begin
      n_bad++; $display("FAIL wait_full_sample: got %h/%h want %h/0a", valid_mask, vdat[0], b(13));
    end
    n_cmp++;
    if (done_mask !== b(16)) begin
      n_bad++; $display("FAIL wait_full_done: got %h want %h", done_mask, b(16));
    end
    n_cmp++;
    if (busy_mask !== (b(17) - b(1))) begin
      n_bad++; $display("FAIL wait_full_busy: got %h want %h", busy_mask, b(17) - b(1));
    end
  endtask

  task automatic test_underrun;
    load_fifo(2, 40'h00_00_00_22_11);
    length = 8'd3; rate_div = 8'd4;
    run(20, 0, -1, -1, 0);
    n_cmp++;
    if (valid_mask !== (b(3) | b(8)) || {vdat[0], vdat[1]} !== 16'h11_22) begin
      n_bad++; $display("FAIL underrun_samples: got %h/%h want %h/1122",
                        valid_mask, {vdat[0], vdat[1]}, b(3) | b(8));
    end
    n_cmp++;
    if (rd_mask !== (b(1) | b(6))) begin
      n_bad++; $display("FAIL underrun_rd: got %h want %h", rd_mask, b(1) | b(6));
    end
    n_cmp++;
    if (done_mask !== b(12)) begin
      n_bad++; $display("FAIL underrun_done: got %h want %h", done_mask, b(12));
    end
    n_cmp++;
    if ({underrun, sample_cnt} !== {1'b1, 8'd2}) begin
      n_bad++; $display("FAIL underrun_status: got underrun=%0b cnt=%0d want 1/2", underrun, sample_cnt);
    end
  endtask

  task automatic test_len0;
    length = 8'd0; rate_div = 8'd4;
    run(8, 0, -1, -1, 0);
    n_cmp++;
    if (done_mask !== b(2)) begin
      n_bad++; $display("FAIL len0_done: got %h want %h", done_mask, b(2));
    end
    n_cmp++;
    if (rd_mask !== 64'd0 || valid_mask !== 64'd0) begin
      n_bad++; $display("FAIL len0_no_read: got rd=%h valid=%h want 0/0", rd_mask, valid_mask);
    end
    n_cmp++;
    if (busy_mask !== (b(1) | b(2))) begin
      n_bad++; $display("FAIL len0_busy: got %h want %h", busy_mask, b(1) | b(2));
    end
    n_cmp++;
    if ({underrun, sample_cnt} !== 9'd0) begin
      n_bad++; $display("FAIL len0_underrun_cleared: got underrun=%0b cnt=%0d want 0/0", underrun, sample_cnt);
    end
  endtask

  task automatic test_abort;
    load_fifo(5, 40'h35_34_33_32_31);
    length = 8'd5; rate_div = 8'd4;
    run(16, 0, -1, 9, 0);
    n_cmp++;
    if (valid_mask !== (b(3) | b(8))) begin
      n_bad++; $display("FAIL abort_valid: got %h want %h", valid_mask, b(3) | b(8));
    end
    n_cmp++;
    if (rd_mask !== (b(1) | b(6))) begin
      n_bad++; $display("FAIL abort_rd: got %h want %h", rd_mask, b(1) | b(6));
    end
    n_cmp++;
    if (done_mask !== b(10)) begin
      n_bad++; $display("FAIL abort_done: got %h want %h", done_mask, b(10));
    end
    n_cmp++;
    if ({dac_data, sample_cnt, underrun} !== {8'h32, 8'd2, 1'b0}) begin
      n_bad++; $display("FAIL abort_hold: got data=%h cnt=%0d underrun=%0b want 32/2/0",
                        dac_data, sample_cnt, underrun);
    end
  endtask

  task automatic test_back_to_back;
    load_fifo(3, 40'h00_00_43_42_41);
    length = 8'd2; rate_div = 8'd0;
    run(12, 0, 3, -1, 0);
    n_cmp++;
    if (valid_mask !== (b(3) | b(6)) || {vdat[0], vdat[1]} !== 16'h41_42) begin
      n_bad++; $display("FAIL b2b_samples: got %h/%h want %h/4142",
                        valid_mask, {vdat[0], vdat[1]}, b(3) | b(6));
    end
    n_cmp++;
    if (rd_mask !== (b(1) | b(4))) begin
      n_bad++; $display("FAIL b2b_rd: got %h want %h", rd_mask, b(1) | b(4));
    end
    n_cmp++;
    if (done_mask !== b(7) || sample_cnt !== 8'd2) begin
      n_bad++; $display("FAIL b2b_done: got %h cnt=%0d want %h cnt=2", done_mask, sample_cnt, b(7));
    end
  endtask

  task automatic test_reset_mid;
    load_fifo(3, 40'h00_00_53_52_51);
    length = 8'd3; rate_div = 8'd4;
    run(5, 0, -1, -1, 0);
    n_cmp++;
    if ({busy, dac_data, sample_cnt} !== {1'b1, 8'h51, 8'd1}) begin
      n_bad++; $display("FAIL mid_hold_state: got busy=%0b data=%h cnt=%0d want 1/51/1",
                        busy, dac_data, sample_cnt);
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({fifo_rd_en, dac_valid, busy, done, underrun, dac_data, sample_cnt} !== 21'd0) begin
      n_bad++; $display("FAIL mid_reset_values: got %h want 0",
                        {fifo_rd_en, dac_valid, busy, done, underrun, dac_data, sample_cnt});
    end
    #2;
    reset = 1'b0;
    @(posedge clk); #1;
    load_fifo(3, 40'h00_00_63_62_61);
    run(22, 0, -1, -1, 0);
    n_cmp++;
    if (valid_mask !== (b(3) | b(8) | b(13)) || {vdat[0], vdat[1], vdat[2]} !== 24'h61_62_63) begin
      n_bad++; $display("FAIL post_reset_play: got %h/%h want %h/616263",
                        valid_mask, {vdat[0], vdat[1], vdat[2]}, b(3) | b(8) | b(13));
    end
    n_cmp++;
    if (done_mask !== b(18)) begin
      n_bad++; $display("FAIL post_reset_done: got %h want %h", done_mask, b(18));
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_wait_full;
    test_underrun;
    test_len0;
    test_abort;
    test_back_to_back;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
